// File: rtl/barrel_scheduler_if.sv
// Handshake and status bundle between the barrel scheduler and the level logic.
interface barrel_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int CNT_W     = 8
);
  logic                 tick;
  logic                 start;
  logic                 over;
  logic                 throw_ack;
  logic [NUM_SLOTS-1:0] retire;
  logic                 throw_req;
  logic [NUM_SLOTS-1:0] slot_start;
  logic [NUM_SLOTS-1:0] slot_kill;
  logic [NUM_SLOTS-1:0] active;
  logic [CNT_W-1:0]     released;
  logic [CNT_W-1:0]     interval;

  // Level/game side: drives ticks, start/over levels, acks and retires.
  modport master (
    output tick, start, over, throw_ack, retire,
    input  throw_req, slot_start, slot_kill, active, released, interval
  );

  // Scheduler side.
  modport slave (
    input  tick, start, over, throw_ack, retire,
    output throw_req, slot_start, slot_kill, active, released, interval
  );
endinterface

// File: rtl/barrel_scheduler.sv
// Barrel release scheduler: tick-based cooldown, Kong throw handshake, then a
// start pulse into the lowest free barrel slot. Interval shrinks per release.
module barrel_scheduler #(
  parameter int NUM_SLOTS     = 4,
  parameter int INTERVAL_INIT = 96,
  parameter int INTERVAL_MIN  = 32,
  parameter int INTERVAL_STEP = 8,
  parameter int CNT_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  barrel_scheduler_if.slave   bus_io
);
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0] INIT_C = CNT_W'(INTERVAL_INIT);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(INTERVAL_MIN);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(INTERVAL_STEP);

  typedef enum logic [1:0] {IDLE, COOLDOWN, THROW, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cooldown_q, cooldown_d;
  logic [CNT_W-1:0]     interval_q, interval_d;
  logic [CNT_W-1:0]     released_q, released_d;
  logic [NUM_SLOTS-1:0] active_q, active_d;
  logic [NUM_SLOTS-1:0] slot_kill_q, slot_kill_d;
  logic                 throw_req_q, throw_req_d;
  logic [IDX_W-1:0]     slot_idx_q, slot_idx_d;
  logic                 slot_vld_q, slot_vld_d;

  logic [NUM_SLOTS-1:0] avail_mask;
  logic [NUM_SLOTS-1:0] release_mask;
  logic [IDX_W-1:0]     free_idx;
  logic                 free_any;
  logic [CNT_W-1:0]     interval_dec;

  // Occupancy as it will stand after this cycle's retires. Sampled on the
  // ack cycle, it equals active_q during RELEASE, so the registered index is
  // the lowest free slot as seen in the RELEASE cycle itself.
  assign avail_mask = active_q & ~bus_io.retire;

  // Lowest-index free slot of the post-retire occupancy.
  always_comb begin
    free_idx = '0;
    free_any = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!avail_mask[i]) begin
        free_idx = IDX_W'(i);
        free_any = 1'b1;
      end
    end
  end

  // One-hot start pulse decoded from the RELEASE state and the held index.
  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_start
    assign release_mask[gi] = (state_q == RELEASE) && slot_vld_q &&
                              (slot_idx_q == IDX_W'(gi));
  end

  // Next interval, clamped at the floor without ever wrapping below zero.
  assign interval_dec = ((interval_q > MIN_C) && ((interval_q - MIN_C) > STEP_C))
                        ? (interval_q - STEP_C) : MIN_C;

  // Next-state and output decode; game over overrides everything but reset.
  always_comb begin
    state_d     = state_q;
    cooldown_d  = cooldown_q;
    interval_d  = interval_q;
    released_d  = released_q;
    active_d    = avail_mask | release_mask;
    slot_kill_d = '0;
    slot_idx_d  = slot_idx_q;
    slot_vld_d  = slot_vld_q;

    if (bus_io.over && (state_q != IDLE)) begin
      state_d     = IDLE;
      slot_kill_d = active_q;
      active_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus_io.start && !bus_io.over) begin
            state_d    = COOLDOWN;
            cooldown_d = INIT_C;
            interval_d = INIT_C;
            released_d = '0;
          end
        end
        COOLDOWN: begin
          if (cooldown_q == '0) begin
            if (!(&active_q)) state_d = THROW;
          end else if (bus_io.tick) begin
            cooldown_d = cooldown_q - CNT_W'(1);
          end
        end
        THROW: begin
          if (bus_io.throw_ack) begin
            state_d    = RELEASE;
            slot_idx_d = free_idx;
            slot_vld_d = free_any;
          end
        end
        RELEASE: begin
          state_d = COOLDOWN;
          if (slot_vld_q) begin
            released_d = (&released_q) ? released_q : (released_q + CNT_W'(1));
            interval_d = interval_dec;
            cooldown_d = interval_dec;
          end else begin
            cooldown_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    throw_req_d = (state_d == THROW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cooldown_q  <= '0;
      interval_q  <= INIT_C;
      released_q  <= '0;
      active_q    <= '0;
      slot_kill_q <= '0;
      throw_req_q <= 1'b0;
      slot_idx_q  <= '0;
      slot_vld_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cooldown_q  <= cooldown_d;
      interval_q  <= interval_d;
      released_q  <= released_d;
      active_q    <= active_d;
      slot_kill_q <= slot_kill_d;
      throw_req_q <= throw_req_d;
      slot_idx_q  <= slot_idx_d;
      slot_vld_q  <= slot_vld_d;
    end
  end

  assign bus_io.throw_req  = throw_req_q;
  assign bus_io.slot_start = release_mask;
  assign bus_io.slot_kill  = slot_kill_q;
  assign bus_io.active     = active_q;
  assign bus_io.released   = released_q;
  assign bus_io.interval   = interval_q;
endmodule

// File: tb/tb_barrel_scheduler.sv
// Self-checking bench for barrel_scheduler: behavioural model plus directed
// scenarios with hand-computed expectations.
module tb_barrel_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrel_scheduler_if #(.NUM_SLOTS(4), .CNT_W(8)) bus ();

  barrel_scheduler #(
    .NUM_SLOTS(4), .INTERVAL_INIT(96), .INTERVAL_MIN(32),
    .INTERVAL_STEP(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .bus_io(bus)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int tick_per = 4;
  int tcnt = 0;
  bit last_tick = 1'b0;

  // Model: phase 0 idle, 1 waiting out the cooldown, 2 Kong throwing, 3 releasing.
  int       m_phase = 0;
  int       m_wait = 0;
  int       m_interval = 96;
  int       m_released = 0;
  bit [3:0] m_inplay = '0;
  bit [3:0] m_kill = '0;
  bit       m_req = 1'b0;

  function automatic int lowest_free(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_start();
    int lf;
    lf = lowest_free(m_inplay);
    if (m_phase == 3 && lf >= 0) return 4'(1 << lf);
    return 4'b0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every active edge from the inputs applied in that cycle.
  always @(posedge clk) begin : model
    int lf;
    bit [3:0] nxt;
    if (rst) begin
      m_phase = 0; m_wait = 0; m_interval = 96; m_released = 0;
      m_inplay = '0; m_kill = '0; m_req = 1'b0;
    end else begin
      m_kill = '0;
      if (bus.over && m_phase != 0) begin
        m_kill = m_inplay;
        m_inplay = '0;
        m_phase = 0;
      end else begin
        nxt = m_inplay & ~bus.retire;
        case (m_phase)
          0: if (bus.start && !bus.over) begin
               m_phase = 1; m_interval = 96; m_released = 0; m_wait = 96;
             end
          1: if (m_wait == 0) begin
               if (m_inplay != 4'hF) m_phase = 2;
             end else if (bus.tick) m_wait = m_wait - 1;
          2: if (bus.throw_ack) m_phase = 3;
          default: begin
            lf = lowest_free(m_inplay);
            if (lf >= 0) begin
              nxt[lf] = 1'b1;
              m_released = (m_released < 255) ? m_released + 1 : 255;
              m_interval = (m_interval - 8 < 32) ? 32 : m_interval - 8;
              m_wait = m_interval;
            end else m_wait = 0;
            m_phase = 1;
          end
        endcase
        m_inplay = nxt;
      end
      m_req = (m_phase == 2);
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_throw_req", 32'(bus.throw_req), 32'(m_req));
      chk("cyc_slot_start", 32'(bus.slot_start), 32'(exp_start()));
      chk("cyc_slot_kill", 32'(bus.slot_kill), 32'(m_kill));
      chk("cyc_active", 32'(bus.active), 32'(m_inplay));
      chk("cyc_released", 32'(bus.released), 32'(m_released));
      chk("cyc_interval", 32'(bus.interval), 32'(m_interval));
    end
  end

  // Apply one cycle of inputs, then advance past the next active edge.
  task automatic step(input logic [3:0] r, input logic a);
    bus.retire = r;
    bus.throw_ack = a;
    bus.tick = (tick_per > 0) && ((tcnt % tick_per) == tick_per - 1);
    last_tick = bus.tick;
    tcnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_throw();
    int n;
    n = 0;
    while (!m_req && n < 5000) begin
      step(4'b0000, 1'b0);
      n++;
    end
    chk("wait_throw", 32'(m_req), 32'd1);
  endtask

  // Leaves the scheduler in its RELEASE cycle (ack given one cycle after the request).
  task automatic go_release();
    wait_throw();
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
  endtask

  int exp_iv [6] = '{48, 40, 32, 32, 32, 32};

  initial begin : main
    int ntick;
    int n;
    bit seen;
    bus.tick = 0; bus.start = 0; bus.over = 0; bus.throw_ack = 0; bus.retire = '0;
    repeat (3) step(4'b0000, 1'b0);
    chk_en = 1'b1;
    rst = 1'b0;
    step(4'b0000, 1'b0);
    chk("rst_throw_req", 32'(bus.throw_req), 32'd0);
    chk("rst_active", 32'(bus.active), 32'd0);
    chk("rst_released", 32'(bus.released), 32'd0);
    chk("rst_interval", 32'(bus.interval), 32'd96);
    chk("rst_slot_kill", 32'(bus.slot_kill), 32'd0);

    // First release: 96 ticks of cooldown, tick every 4 clocks.
    tcnt = 0;
    bus.start = 1'b1;
    step(4'b0000, 1'b0);
    bus.start = 1'b0;
    ntick = 0; n = 0;
    while (!bus.throw_req && n < 2000) begin
      step(4'b0000, 1'b0);
      if (last_tick) ntick++;
      n++;
    end
    chk("ticks_to_throw", 32'(ntick), 32'd96);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    chk("first_slot_start", 32'(bus.slot_start), 32'b0001);
    step(4'b0000, 1'b0);
    chk("first_active", 32'(bus.active), 32'b0001);
    chk("first_released", 32'(bus.released), 32'd1);
    chk("first_interval", 32'(bus.interval), 32'd88);

    // Fill all four slots, then confirm the scheduler holds without throwing.
    tick_per = 1;
    for (int k = 0; k < 3; k++) begin
      go_release();
      step(4'b0000, 1'b0);
    end
    seen = 1'b0;
    repeat (200) begin
      step(4'b0000, 1'b0);
      if (bus.throw_req) seen = 1'b1;
    end
    chk("full_no_throw", 32'(seen), 32'd0);
    chk("full_active", 32'(bus.active), 32'hF);
    chk("full_released", 32'(bus.released), 32'd4);
    step(4'b0100, 1'b0);
    step(4'b0000, 1'b0);
    chk("freed_throw_req", 32'(bus.throw_req), 32'd1);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b1);
    chk("refill_slot_start", 32'(bus.slot_start), 32'b0100);
    step(4'b0000, 1'b0);
    chk("refill_interval", 32'(bus.interval), 32'd56);

    // Interval ramp down to the floor, retiring slot 0 before each release.
    for (int k = 0; k < 6; k++) begin
      step(4'b0001, 1'b0);
      go_release();
      chk("ramp_slot_start", 32'(bus.slot_start), 32'b0001);
      step(4'b0000, 1'b0);
      chk("ramp_interval", 32'(bus.interval), 32'(exp_iv[k]));
    end
    chk("ramp_released", 32'(bus.released), 32'd11);

    // Game over in THROW with 1011 in play.
    step(4'b0100, 1'b0);
    wait_throw();
    chk("over_pre_active", 32'(bus.active), 32'b1011);
    bus.over = 1'b1;
    step(4'b0000, 1'b0);
    bus.over = 1'b0;
    chk("over_slot_kill", 32'(bus.slot_kill), 32'b1011);
    chk("over_active", 32'(bus.active), 32'd0);
    chk("over_throw_req", 32'(bus.throw_req), 32'd0);
    chk("over_hold_released", 32'(bus.released), 32'd12 - 32'd1);
    step(4'b0000, 1'b0);
    chk("over_kill_one_cycle", 32'(bus.slot_kill), 32'd0);
    bus.start = 1'b1;
    step(4'b0000, 1'b0);
    bus.start = 1'b0;
    chk("restart_released", 32'(bus.released), 32'd0);
    chk("restart_interval", 32'(bus.interval), 32'd96);

    // Retire against the slot being released, then against an idle slot.
    go_release();
    step(4'b0000, 1'b0);
    go_release();
    chk("r1_slot_start", 32'(bus.slot_start), 32'b0010);
    step(4'b0010, 1'b0);
    chk("r1_active", 32'(bus.active), 32'b0011);
    step(4'b1000, 1'b0);
    chk("r3_idle_active", 32'(bus.active), 32'b0011);
    go_release();
    step(4'b0001, 1'b0);
    chk("mixed_active", 32'(bus.active), 32'b0110);

    // Reset in the middle of a throw.
    wait_throw();
    chk("prerst_active", 32'(bus.active), 32'b0110);
    rst = 1'b1;
    step(4'b0000, 1'b0);
    chk("mid_rst_throw_req", 32'(bus.throw_req), 32'd0);
    chk("mid_rst_active", 32'(bus.active), 32'd0);
    chk("mid_rst_slot_kill", 32'(bus.slot_kill), 32'd0);
    chk("mid_rst_released", 32'(bus.released), 32'd0);
    chk("mid_rst_interval", 32'(bus.interval), 32'd96);
    rst = 1'b0;
    step(4'b0000, 1'b0);
    chk("post_rst_slot_kill", 32'(bus.slot_kill), 32'd0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
